pipe_stage_buf: RTL and testbench

Parametrised inter-stage pipeline buffer for the Balotelli core. It is the generalised successor of the fixed-field Id2Ex/If2Id-style registers: one wide payload bus with a configurable reset/bubble value, a valid/ready handshake in both directions, a Ctrl hold (stall) and flush (bubble insertion), and an optional two-entry skid mode that breaks the combinational ready path. It sits between any two pipeline stages; the stage-specific fields are concatenated by the instantiating stage.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_data_reg.sv | 32 +++
 rtl/pipe_stage_buf.sv | 163 ++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for inter-stage pipeline buffers: state encodings,
// per-stage payload defaults and a small occupancy helper.
package pipe_pkg;

  // Buffer states; the encoding doubles as the entry count.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  // Generic stage defaults.
  localparam int                    PIPE_WIDTH   = 256;
  localparam logic [PIPE_WIDTH-1:0] PIPE_RST_VAL = '0;

  // Per-stage defaults used by the instantiating stages.
  localparam int                     IF2ID_WIDTH   = 64;
  localparam logic [IF2ID_WIDTH-1:0] IF2ID_RST_VAL = '0;
  localparam int                     ID2EX_WIDTH   = 256;
  localparam logic [ID2EX_WIDTH-1:0] ID2EX_RST_VAL = '0;

  // Number of entries held in a given state.
  function automatic logic [1:0] occ_of_state(input logic [1:0] st);
    logic [1:0] occ;
    occ = 2'd0;
    case (st)
      ST_ONE:  occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-wide payload register: asynchronous active-low reset to RST_VAL,
// synchronous clear back to RST_VAL, and load enable. Clear wins over load.
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Payload storage: reset/clear to the bubble value, otherwise load on enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= RST_VAL;
    end else if (i_clr) begin
      r_q <= RST_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer with valid/ready on both sides, Ctrl hold and
// flush, and an optional two-entry skid mode (registered InReady).
//
// Handshake: a beat moves across a port on a rising edge where valid and
// ready are both 1; valid never waits on ready, and a beat offered while
// ready=0 stays unaccepted (nothing is captured or consumed).
//
// Occupancy mirrors the FSM state one-to-one (EMPTY/ONE/FULL -> 0/1/2) and
// serves as the observable state.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               SKID    = 1,
  parameter int               CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  input  logic             Hold,
  input  logic             Flush,
  output logic [1:0]       Occupancy,
  output logic [CNT_W-1:0] DropCnt
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W:0]   w_drop_sum;
  logic [1:0]       w_occ;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_m_load;
  logic             w_m_clr;
  logic [WIDTH-1:0] w_m_d;
  logic [WIDTH-1:0] w_m_q;
  logic             w_s_load;
  logic             w_s_clr;
  logic [WIDTH-1:0] w_s_q;

  assign w_occ       = occ_of_state(r_state);
  assign w_out_valid = (r_state != ST_EMPTY) & !Hold;
  // Skid mode looks only at registered state, so OutReady never reaches InReady.
  assign w_in_ready  = Rst & !Hold & !Flush &
                       ((SKID != 0) ? (r_state != ST_FULL) : (!w_out_valid | OutReady));
  assign w_in_fire   = InValid & w_in_ready;
  assign w_out_fire  = w_out_valid & OutReady;

  // Next-state and register controls; Flush outranks Hold, which outranks the handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_m_load    = 1'b0;
    w_m_clr     = 1'b0;
    w_m_d       = InData;
    w_s_load    = 1'b0;
    w_s_clr     = 1'b0;
    if (Flush) begin
      w_state_nxt = ST_EMPTY;
      w_m_clr     = 1'b1;
      w_s_clr     = 1'b1;
    end else if (!Hold) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_ONE;
            w_m_load    = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_m_load = 1'b1;
          end else if (w_in_fire) begin
            // Downstream stalled: park the new beat in the skid entry.
            w_state_nxt = ST_FULL;
            w_s_load    = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
            w_m_clr     = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_state_nxt = ST_ONE;
            w_m_load    = 1'b1;
            w_m_d       = w_s_q;
            w_s_clr     = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_m_clr     = 1'b1;
          w_s_clr     = 1'b1;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Carry out of the add means the count would wrap, so pin it at all-ones.
  assign w_drop_sum = {1'b0, r_drop_cnt} + {{(CNT_W-1){1'b0}}, w_occ};

  // Flush-drop counter: adds the discarded entries, saturating.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_drop_cnt <= '0;
    end else if (Flush) begin
      r_drop_cnt <= w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
    end
  end

  pipe_data_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_m_reg (
    .i_clk   (Clk),
    .i_rst_n (Rst),
    .i_load  (w_m_load),
    .i_clr   (w_m_clr),
    .i_d     (w_m_d),
    .o_q     (w_m_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_data_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_s_reg (
        .i_clk   (Clk),
        .i_rst_n (Rst),
        .i_load  (w_s_load),
        .i_clr   (w_s_clr),
        .i_d     (InData),
        .o_q     (w_s_q)
      );
    end else begin : g_no_skid
      assign w_s_q = RST_VAL;
    end
  endgenerate

  assign InReady   = w_in_ready;
  assign OutValid  = w_out_valid;
  assign OutData   = w_m_q;
  assign Occupancy = w_occ;
  assign DropCnt   = r_drop_cnt;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: one skid instance (a_*, CNT_W=3 so the
// drop counter saturates quickly) and one single-entry instance (b_*).
// Inputs change 1 time unit after the rising edge; outputs are checked after that.
module tb_pipe_stage_buf;

  localparam int         W    = 8;
  localparam logic [7:0] RV   = 8'h5A;
  localparam int         CW_A = 3;
  localparam int         CW_B = 16;

  logic clk;
  logic rst_n;

  logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_hold, a_flush;
  logic [W-1:0]    a_in_data, a_out_data;
  logic [1:0]      a_occ;
  logic [CW_A-1:0] a_drop;

  logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_hold, b_flush;
  logic [W-1:0]    b_in_data, b_out_data;
  logic [1:0]      b_occ;
  logic [CW_B-1:0] b_drop;

  int n_vec;
  int n_err;

  pipe_stage_buf #(.WIDTH(W), .RST_VAL(RV), .SKID(1), .CNT_W(CW_A)) dut_a (
    .Clk(clk), .Rst(rst_n),
    .InValid(a_in_valid), .InReady(a_in_ready), .InData(a_in_data),
    .OutValid(a_out_valid), .OutReady(a_out_ready), .OutData(a_out_data),
    .Hold(a_hold), .Flush(a_flush), .Occupancy(a_occ), .DropCnt(a_drop)
  );

  pipe_stage_buf #(.WIDTH(W), .RST_VAL(RV), .SKID(0), .CNT_W(CW_B)) dut_b (
    .Clk(clk), .Rst(rst_n),
    .InValid(b_in_valid), .InReady(b_in_ready), .InData(b_in_data),
    .OutValid(b_out_valid), .OutReady(b_out_ready), .OutData(b_out_data),
    .Hold(b_hold), .Flush(b_flush), .Occupancy(b_occ), .DropCnt(b_drop)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fill instance a with n beats starting at base while downstream is stalled.
  task automatic fill_a(input int n, input logic [W-1:0] base);
    a_out_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = base + W'(k);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_hold = 1'b0; a_flush = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_hold = 1'b0; b_flush = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", a_out_valid); end
    n_vec++; if (a_out_data !== RV) begin n_err++; $display("FAIL rst_out_data got %h exp %h", a_out_data, RV); end
    n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b exp 0", a_in_ready); end
    n_vec++; if (a_occ !== 2'd0) begin n_err++; $display("FAIL rst_occ got %0d exp 0", a_occ); end
    n_vec++; if (a_drop !== '0) begin n_err++; $display("FAIL rst_drop got %0d exp 0", a_drop); end
    n_vec++; if (b_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_b_in_ready got %b exp 0", b_in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready got %b exp 1", a_in_ready); end
    n_vec++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_b_in_ready got %b exp 1", b_in_ready); end
  endtask

  task automatic test_stream();
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a_in_valid = (i < 8);
      a_in_data  = W'(i + 1);
      b_in_valid = (i < 8);
      b_in_data  = W'(i + 1);
      @(posedge clk); #1;
      if (i < 8) begin
        n_vec++; if (a_out_valid !== 1'b1 || a_out_data !== W'(i + 1)) begin
          n_err++; $display("FAIL stream_a[%0d] got v=%b d=%h exp v=1 d=%h", i, a_out_valid, a_out_data, W'(i + 1));
        end
        n_vec++; if (b_out_valid !== 1'b1 || b_out_data !== W'(i + 1)) begin
          n_err++; $display("FAIL stream_b[%0d] got v=%b d=%h exp v=1 d=%h", i, b_out_valid, b_out_data, W'(i + 1));
        end
      end else begin
        n_vec++; if (a_out_valid !== 1'b0 || a_out_data !== RV) begin
          n_err++; $display("FAIL stream_a_end got v=%b d=%h exp v=0 d=%h", a_out_valid, a_out_data, RV);
        end
        n_vec++; if (b_out_valid !== 1'b0 || b_out_data !== RV) begin
          n_err++; $display("FAIL stream_b_end got v=%b d=%h exp v=0 d=%h", b_out_valid, b_out_data, RV);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] beats [3];
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_in_data = beats[i];
      b_in_valid = 1'b1; b_in_data = beats[i];
      @(posedge clk); #1;
    end
    n_vec++; if (a_occ !== 2'd2) begin n_err++; $display("FAIL bp_a_occ got %0d exp 2", a_occ); end
    n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_a_in_ready got %b exp 0", a_in_ready); end
    n_vec++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h11) begin
      n_err++; $display("FAIL bp_a_head got v=%b d=%h exp v=1 d=11", a_out_valid, a_out_data);
    end
    n_vec++; if (b_occ !== 2'd1) begin n_err++; $display("FAIL bp_b_occ got %0d exp 1", b_occ); end
    n_vec++; if (b_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_b_in_ready got %b exp 0", b_in_ready); end
    n_vec++; if (b_out_data !== 8'h11) begin n_err++; $display("FAIL bp_b_head got %h exp 11", b_out_data); end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h22 || a_occ !== 2'd1) begin
      n_err++; $display("FAIL bp_a_second got v=%b d=%h occ=%0d exp v=1 d=22 occ=1", a_out_valid, a_out_data, a_occ);
    end
    n_vec++; if (b_out_valid !== 1'b0 || b_occ !== 2'd0) begin
      n_err++; $display("FAIL bp_b_drain got v=%b occ=%0d exp v=0 occ=0", b_out_valid, b_occ);
    end
    @(posedge clk); #1;
    n_vec++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_out_data !== RV) begin
      n_err++; $display("FAIL bp_a_drain got v=%b occ=%0d d=%h exp v=0 occ=0 d=%h", a_out_valid, a_occ, a_out_data, RV);
    end
  endtask

  task automatic test_hold();
    fill_a(1, 8'h33);
    a_hold = 1'b1; a_in_valid = 1'b1; a_in_data = 8'h44; a_out_ready = 1'b1;
    #1;
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL hold_out_valid got %b exp 0", a_out_valid); end
    n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready got %b exp 0", a_in_ready); end
    n_vec++; if (a_out_data !== 8'h33) begin n_err++; $display("FAIL hold_data got %h exp 33", a_out_data); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_vec++; if (a_occ !== 2'd1 || a_out_data !== 8'h33 || a_out_valid !== 1'b0) begin
        n_err++; $display("FAIL hold_cyc[%0d] got occ=%0d d=%h v=%b exp occ=1 d=33 v=0", i, a_occ, a_out_data, a_out_valid);
      end
    end
    a_hold = 1'b0; a_in_valid = 1'b0;
    #1;
    n_vec++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h33) begin
      n_err++; $display("FAIL hold_release got v=%b d=%h exp v=1 d=33", a_out_valid, a_out_data);
    end
    @(posedge clk); #1;
    n_vec++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
      n_err++; $display("FAIL hold_no_dup got v=%b occ=%0d exp v=0 occ=0", a_out_valid, a_occ);
    end
  endtask

  task automatic test_flush();
    fill_a(2, 8'h66);
    n_vec++; if (a_occ !== 2'd2) begin n_err++; $display("FAIL flush_pre_occ got %0d exp 2", a_occ); end
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 8'h99;
    #1;
    n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %b exp 0", a_in_ready); end
    @(posedge clk); #1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    n_vec++; if (a_occ !== 2'd0 || a_out_data !== RV || a_out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_empty got occ=%0d d=%h v=%b exp occ=0 d=%h v=0", a_occ, a_out_data, a_out_valid, RV);
    end
    n_vec++; if (a_drop !== 3'd2) begin n_err++; $display("FAIL flush_drop got %0d exp 2", a_drop); end
    @(posedge clk); #1;
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_beat_leak got v=%b d=%h exp v=0", a_out_valid, a_out_data); end
  endtask

  task automatic test_flush_hold_sat();
    // Flush while empty leaves the count alone.
    a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    n_vec++; if (a_drop !== 3'd2) begin n_err++; $display("FAIL flush_empty_drop got %0d exp 2", a_drop); end
    for (int i = 0; i < 2; i++) begin
      fill_a(2, 8'hA0);
      a_flush = 1'b1;
      @(posedge clk); #1;
      a_flush = 1'b0;
    end
    n_vec++; if (a_drop !== 3'd6) begin n_err++; $display("FAIL sat_preset got %0d exp 6", a_drop); end
    fill_a(2, 8'hB0);
    a_flush = 1'b1; a_hold = 1'b1; a_in_valid = 1'b1; a_in_data = 8'hEE;
    @(posedge clk); #1;
    a_flush = 1'b0; a_hold = 1'b0; a_in_valid = 1'b0;
    n_vec++; if (a_drop !== 3'd7) begin n_err++; $display("FAIL sat_drop got %0d exp 7", a_drop); end
    n_vec++; if (a_occ !== 2'd0 || a_out_data !== RV) begin
      n_err++; $display("FAIL flush_hold_empty got occ=%0d d=%h exp occ=0 d=%h", a_occ, a_out_data, RV);
    end
    fill_a(1, 8'hC0);
    a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    n_vec++; if (a_drop !== 3'd7) begin n_err++; $display("FAIL sat_no_wrap got %0d exp 7", a_drop); end
  endtask

  task automatic test_async_reset();
    fill_a(1, 8'hD1);
    n_vec++; if (a_occ !== 2'd1) begin n_err++; $display("FAIL arst_pre_occ got %0d exp 1", a_occ); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0 || a_out_data !== RV) begin
      n_err++; $display("FAIL arst_empty got occ=%0d v=%b d=%h exp occ=0 v=0 d=%h", a_occ, a_out_valid, a_out_data, RV);
    end
    n_vec++; if (a_drop !== 3'd0 || a_in_ready !== 1'b0) begin
      n_err++; $display("FAIL arst_ctrl got drop=%0d rdy=%b exp drop=0 rdy=0", a_drop, a_in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Test sequence and final report
  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_hold();
    test_flush();
    test_flush_hold_sat();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
